// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared opcodes, FSM encoding and widths for the ALU scheduler
package alu_sched_pkg;

   localparam int ALU_W     = 8;
   localparam int DEF_CNT_W = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_CMP  = 3'b101;
   localparam logic [2:0] OP_SHLA = 3'b110;
   localparam logic [2:0] OP_SHLB = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Requesters never drive carry_in: subtract needs the +1 of two's complement, everything else adds 0.
   function automatic logic carry_in_for(input logic [2:0] op);
      return (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - command/response bundle between requesters and the ALU scheduler
interface alu_sched_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic [1:0]        i_req_valid;
   logic [1:0]        o_req_ready;
   logic [2:0]        i_req0_op;
   logic [DATA_W-1:0] i_req0_a;
   logic [DATA_W-1:0] i_req0_b;
   logic [2:0]        i_req1_op;
   logic [DATA_W-1:0] i_req1_a;
   logic [DATA_W-1:0] i_req1_b;
   logic              o_res_valid;
   logic              i_res_ready;
   logic              o_res_id;
   logic [DATA_W-1:0] o_res_data;
   logic              o_res_cflag;
   logic              o_res_carry;
   logic              o_busy;
   logic [CNT_W-1:0]  o_cnt0;
   logic [CNT_W-1:0]  o_cnt1;

   // Requesters and the response consumer
   modport master (
      output i_req_valid, i_req0_op, i_req0_a, i_req0_b,
      output i_req1_op, i_req1_a, i_req1_b, i_res_ready,
      input  o_req_ready, o_res_valid, o_res_id, o_res_data,
      input  o_res_cflag, o_res_carry, o_busy, o_cnt0, o_cnt1
   );

   // The scheduler
   modport slave (
      input  i_req_valid, i_req0_op, i_req0_a, i_req0_b,
      input  i_req1_op, i_req1_a, i_req1_b, i_res_ready,
      output o_req_ready, o_res_valid, o_res_id, o_res_data,
      output o_res_cflag, o_res_carry, o_busy, o_cnt0, o_cnt1
   );
endinterface

// File: rtl/alu_sched_alu.sv
// rtl/alu_sched_alu.sv - combinational ALU with shared full adder/subtractor
module alu_sched_alu
   import alu_sched_pkg::*;
#(
   parameter int DATA_W = ALU_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              carry_in,
   output logic [DATA_W-1:0] out,
   output logic              c_flag,
   output logic              carry_out
);

   // Full adder/subtractor: carry_in=1 inverts B and adds one, giving A-B.
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;

   assign b_eff     = carry_in ? ~b : b;
   assign sum       = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, carry_in};
   assign carry_out = sum[DATA_W];
   assign c_flag    = (a > b);

   // Result select; compare returns the A>B flag zero-extended to the data width.
   always_comb begin
      out = '0;
      case (op)
         OP_ADD:  out = sum[DATA_W-1:0];
         OP_SUB:  out = sum[DATA_W-1:0];
         OP_AND:  out = a & b;
         OP_OR:   out = a | b;
         OP_XOR:  out = a ^ b;
         OP_CMP:  out = {{(DATA_W-1){1'b0}}, c_flag};
         OP_SHLA: out = {a[DATA_W-2:0], 1'b0};
         OP_SHLB: out = {b[DATA_W-2:0], 1'b0};
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler sharing one ALU between two requesters
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int DATA_W = ALU_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic      i_clk,
   input  logic      i_rst,
   alu_sched_if.slave bus
);

   state_t            state;
   logic              rr_ptr;
   logic              cur_id;
   logic [2:0]        op_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [1:0]        grant;

   logic              res_valid;
   logic              res_id;
   logic [DATA_W-1:0] res_data;
   logic              res_cflag;
   logic              res_carry;
   logic              busy;
   logic [CNT_W-1:0]  cnt0;
   logic [CNT_W-1:0]  cnt1;

   logic              carry_in;
   logic [DATA_W-1:0] alu_out;
   logic              alu_cflag;
   logic              alu_carry;

   assign carry_in = carry_in_for(op_r);

   alu_sched_alu #(.DATA_W(DATA_W)) u_alu (
      .op        (op_r),
      .a         (a_r),
      .b         (b_r),
      .carry_in  (carry_in),
      .out       (alu_out),
      .c_flag    (alu_cflag),
      .carry_out (alu_carry)
   );

   // Arbitration: only in IDLE; on contention rr_ptr names the favoured requester.
   // Held low during reset so a pending command never shows as accepted.
   always_comb begin
      grant = 2'b00;
      if (state == S_IDLE && !i_rst) begin
         grant[0] = bus.i_req_valid[0] & (~bus.i_req_valid[1] | ~rr_ptr);
         grant[1] = bus.i_req_valid[1] & (~bus.i_req_valid[0] |  rr_ptr);
      end
   end

   assign bus.o_req_ready = grant;
   assign bus.o_res_valid = res_valid;
   assign bus.o_res_id    = res_id;
   assign bus.o_res_data  = res_data;
   assign bus.o_res_cflag = res_cflag;
   assign bus.o_res_carry = res_carry;
   assign bus.o_busy      = busy;
   assign bus.o_cnt0      = cnt0;
   assign bus.o_cnt1      = cnt1;

   // Scheduler FSM: accept one command, run it through the ALU, hold the response until taken.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         rr_ptr    <= 1'b0;
         cur_id    <= 1'b0;
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         res_data  <= '0;
         res_cflag <= 1'b0;
         res_carry <= 1'b0;
         busy      <= 1'b0;
         cnt0      <= '0;
         cnt1      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|grant) begin
                  cur_id <= grant[1];
                  rr_ptr <= ~grant[1];
                  op_r   <= grant[1] ? bus.i_req1_op : bus.i_req0_op;
                  a_r    <= grant[1] ? bus.i_req1_a  : bus.i_req0_a;
                  b_r    <= grant[1] ? bus.i_req1_b  : bus.i_req0_b;
                  busy   <= 1'b1;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_data  <= alu_out;
               res_cflag <= alu_cflag;
               res_carry <= alu_carry;
               res_id    <= cur_id;
               res_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (bus.i_res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  if (cur_id) begin
                     cnt1 <= (cnt1 == {CNT_W{1'b1}}) ? cnt1 : cnt1 + 1'b1;
                  end else begin
                     cnt0 <= (cnt0 == {CNT_W{1'b1}}) ? cnt0 : cnt0 + 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched
module tb_alu_sched;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   alu_sched_if #(.DATA_W(8), .CNT_W(8)) bus ();

   alu_sched dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_cmd(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] data, output logic cflag, output logic rid, output logic ok);
      int n;
      ok = 1'b0; data = '0; cflag = 1'b0; rid = 1'b0;
      @(negedge clk);
      if (id) begin bus.i_req1_op = op; bus.i_req1_a = a; bus.i_req1_b = b; end
      else    begin bus.i_req0_op = op; bus.i_req0_a = a; bus.i_req0_b = b; end
      bus.i_req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (!bus.o_req_ready[id] && n < 10) begin @(negedge clk); #1; n++; end
      if (!bus.o_req_ready[id]) begin
         compared++; mismatched++;
         $display("FAIL cmd_accept_timeout: ready=%b want bit %0d set", bus.o_req_ready, id);
         bus.i_req_valid = 2'b00;
         return;
      end
      @(negedge clk);
      bus.i_req_valid[id] = 1'b0;
      n = 0;
      while (!bus.o_res_valid && n < 10) begin @(negedge clk); n++; end
      if (!bus.o_res_valid) begin
         compared++; mismatched++;
         $display("FAIL cmd_resp_timeout: res_valid=%b want 1", bus.o_res_valid);
         return;
      end
      data = bus.o_res_data; cflag = bus.o_res_cflag; rid = bus.o_res_id; ok = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      @(negedge clk);
      compared++; if (bus.o_req_ready !== 2'b00) begin mismatched++; $display("FAIL rst_ready: got %b want 00", bus.o_req_ready); end
      compared++; if (bus.o_res_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", bus.o_res_valid); end
      compared++; if (bus.o_res_data !== 8'h00 || bus.o_res_id !== 1'b0 || bus.o_res_cflag !== 1'b0 || bus.o_res_carry !== 1'b0) begin
         mismatched++; $display("FAIL rst_payload: got id=%b data=%h cf=%b co=%b want all 0", bus.o_res_id, bus.o_res_data, bus.o_res_cflag, bus.o_res_carry); end
      compared++; if (bus.o_busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
      compared++; if (bus.o_cnt0 !== 8'h00 || bus.o_cnt1 !== 8'h00) begin mismatched++; $display("FAIL rst_cnt: got %h/%h want 00/00", bus.o_cnt0, bus.o_cnt1); end
      rst = 1'b0;
   endtask

   task automatic test_req0_add();
      @(negedge clk);
      bus.i_req0_op = 3'b000; bus.i_req0_a = 8'h0F; bus.i_req0_b = 8'h01; bus.i_req_valid = 2'b01;
      #1;
      compared++; if (bus.o_req_ready !== 2'b01) begin mismatched++; $display("FAIL add_ready: got %b want 01", bus.o_req_ready); end
      @(negedge clk);
      bus.i_req_valid = 2'b00;
      compared++; if (bus.o_busy !== 1'b1 || bus.o_res_valid !== 1'b0) begin mismatched++; $display("FAIL add_exec: busy=%b valid=%b want 1/0", bus.o_busy, bus.o_res_valid); end
      @(negedge clk);
      compared++; if (bus.o_res_valid !== 1'b1) begin mismatched++; $display("FAIL add_latency: valid=%b want 1", bus.o_res_valid); end
      compared++; if (bus.o_res_data !== 8'h10 || bus.o_res_cflag !== 1'b1 || bus.o_res_carry !== 1'b0 || bus.o_res_id !== 1'b0) begin
         mismatched++; $display("FAIL add_payload: got d=%h cf=%b co=%b id=%b want 10/1/0/0", bus.o_res_data, bus.o_res_cflag, bus.o_res_carry, bus.o_res_id); end
      @(negedge clk);
      compared++; if (bus.o_res_valid !== 1'b0 || bus.o_cnt0 !== 8'h01 || bus.o_busy !== 1'b0) begin
         mismatched++; $display("FAIL add_done: valid=%b cnt0=%h busy=%b want 0/01/0", bus.o_res_valid, bus.o_cnt0, bus.o_busy); end
   endtask

   task automatic test_req1_sub();
      @(negedge clk);
      bus.i_req1_op = 3'b001; bus.i_req1_a = 8'h05; bus.i_req1_b = 8'h07; bus.i_req_valid = 2'b10;
      #1;
      compared++; if (bus.o_req_ready !== 2'b10) begin mismatched++; $display("FAIL sub_ready: got %b want 10", bus.o_req_ready); end
      @(negedge clk);
      bus.i_req_valid = 2'b00;
      compared++; if (dut.carry_in !== 1'b1) begin mismatched++; $display("FAIL sub_carry_in: got %b want 1", dut.carry_in); end
      @(negedge clk);
      compared++; if (bus.o_res_valid !== 1'b1 || bus.o_res_data !== 8'hFE || bus.o_res_cflag !== 1'b0 || bus.o_res_id !== 1'b1) begin
         mismatched++; $display("FAIL sub_payload: got v=%b d=%h cf=%b id=%b want 1/FE/0/1", bus.o_res_valid, bus.o_res_data, bus.o_res_cflag, bus.o_res_id); end
      @(negedge clk);
      compared++; if (bus.o_cnt1 !== 8'h01) begin mismatched++; $display("FAIL sub_cnt1: got %h want 01", bus.o_cnt1); end
   endtask

   task automatic test_ops();
      logic [2:0] t_op [4] = '{3'b101, 3'b101, 3'b111, 3'b100};
      logic [7:0] t_a  [4] = '{8'h09, 8'h03, 8'h00, 8'hFF};
      logic [7:0] t_b  [4] = '{8'h03, 8'h09, 8'hC3, 8'h0F};
      logic [7:0] t_d  [4] = '{8'h01, 8'h00, 8'h86, 8'hF0};
      logic       t_cf [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] d;
      logic cf, rid, ok;
      for (int i = 0; i < 4; i++) begin
         do_cmd(1'b1, t_op[i], t_a[i], t_b[i], d, cf, rid, ok);
         if (ok) begin
            compared++; if (d !== t_d[i] || cf !== t_cf[i] || rid !== 1'b1) begin
               mismatched++; $display("FAIL ops_%0d: got d=%h cf=%b id=%b want %h/%b/1", i, d, cf, rid, t_d[i], t_cf[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      reset_dut();
      @(negedge clk);
      bus.i_req0_op = 3'b010; bus.i_req0_a = 8'hF0; bus.i_req0_b = 8'h3C;
      bus.i_req1_op = 3'b010; bus.i_req1_a = 8'hF0; bus.i_req1_b = 8'h3C;
      bus.i_req_valid = 2'b11;
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (bus.o_res_valid) begin
            compared++; if (bus.o_res_id !== n[0] || bus.o_res_data !== 8'h30) begin
               mismatched++; $display("FAIL b2b_resp_%0d: got id=%b d=%h want %b/30", n, bus.o_res_id, bus.o_res_data, n[0]); end
            n++;
            if (n == 6) bus.i_req_valid = 2'b00;
         end
      end
      compared++; if (n != 6) begin mismatched++; $display("FAIL b2b_count: got %0d responses want 6", n); end
      @(negedge clk);
      compared++; if (bus.o_cnt0 !== 8'd3 || bus.o_cnt1 !== 8'd3) begin mismatched++; $display("FAIL b2b_cnt: got %0d/%0d want 3/3", bus.o_cnt0, bus.o_cnt1); end
   endtask

   task automatic test_backpressure();
      int bad;
      @(negedge clk);
      bus.i_res_ready = 1'b0;
      bus.i_req0_op = 3'b011; bus.i_req0_a = 8'h12; bus.i_req0_b = 8'h21;
      bus.i_req1_op = 3'b100; bus.i_req1_a = 8'hFF; bus.i_req1_b = 8'h0F;
      bus.i_req_valid = 2'b01;
      @(negedge clk);
      bus.i_req_valid = 2'b10;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.o_res_valid !== 1'b1 || bus.o_res_data !== 8'h33 || bus.o_res_id !== 1'b0 || bus.o_res_cflag !== 1'b0 || bus.o_req_ready !== 2'b00) begin
            bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h id=%b cf=%b rdy=%b want 1/33/0/0/00", c, bus.o_res_valid, bus.o_res_data, bus.o_res_id, bus.o_res_cflag, bus.o_req_ready);
         end
      end
      compared++; if (bad != 0) mismatched++;
      bus.i_res_ready = 1'b1;
      @(negedge clk);
      compared++; if (bus.o_res_valid !== 1'b0 || bus.o_cnt0 !== 8'd4 || bus.o_req_ready !== 2'b10) begin
         mismatched++; $display("FAIL bp_release: got v=%b cnt0=%0d rdy=%b want 0/4/10", bus.o_res_valid, bus.o_cnt0, bus.o_req_ready); end
      @(negedge clk);
      bus.i_req_valid = 2'b00;
      @(negedge clk);
      compared++; if (bus.o_res_valid !== 1'b1 || bus.o_res_data !== 8'hF0 || bus.o_res_id !== 1'b1 || bus.o_res_cflag !== 1'b1) begin
         mismatched++; $display("FAIL bp_next: got v=%b d=%h id=%b cf=%b want 1/F0/1/1", bus.o_res_valid, bus.o_res_data, bus.o_res_id, bus.o_res_cflag); end
      @(negedge clk);
      compared++; if (bus.o_cnt1 !== 8'd4 || bus.o_cnt0 !== 8'd4) begin mismatched++; $display("FAIL bp_cnt: got %0d/%0d want 4/4", bus.o_cnt0, bus.o_cnt1); end
   endtask

   task automatic test_reset_mid_exec();
      int seen;
      @(negedge clk);
      bus.i_req0_op = 3'b000; bus.i_req0_a = 8'h01; bus.i_req0_b = 8'h01; bus.i_req_valid = 2'b01;
      @(negedge clk);
      compared++; if (bus.o_busy !== 1'b1) begin mismatched++; $display("FAIL rmid_exec: busy=%b want 1", bus.o_busy); end
      #2 rst = 1'b1;
      #1;
      compared++; if (bus.o_busy !== 1'b0 || bus.o_res_valid !== 1'b0 || bus.o_req_ready !== 2'b00 || bus.o_res_data !== 8'h00) begin
         mismatched++; $display("FAIL rmid_async: busy=%b v=%b rdy=%b d=%h want 0/0/00/00", bus.o_busy, bus.o_res_valid, bus.o_req_ready, bus.o_res_data); end
      compared++; if (bus.o_cnt0 !== 8'h00 || bus.o_cnt1 !== 8'h00) begin mismatched++; $display("FAIL rmid_cnt: got %h/%h want 00/00", bus.o_cnt0, bus.o_cnt1); end
      @(negedge clk);
      rst = 1'b0;
      bus.i_req_valid = 2'b11;
      #1;
      compared++; if (bus.o_req_ready !== 2'b01) begin mismatched++; $display("FAIL rmid_ptr: got %b want 01", bus.o_req_ready); end
      bus.i_req_valid = 2'b00;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.o_res_valid !== 1'b0) seen++;
      end
      compared++; if (seen != 0) begin mismatched++; $display("FAIL rmid_no_resp: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_saturation();
      int n, bad;
      @(negedge clk);
      bus.i_req0_op = 3'b110; bus.i_req0_a = 8'h81; bus.i_req0_b = 8'h00; bus.i_req_valid = 2'b01;
      n = 0; bad = 0;
      for (int c = 0; c < 1000 && n < 260; c++) begin
         @(negedge clk);
         if (bus.o_res_valid) begin
            if (bus.o_res_data !== 8'h02) bad++;
            n++;
            if (n == 260) bus.i_req_valid = 2'b00;
         end
      end
      compared++; if (n != 260) begin mismatched++; $display("FAIL sat_count: got %0d responses want 260", n); end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL sat_data: got %0d wrong results want 0", bad); end
      @(negedge clk);
      compared++; if (bus.o_cnt0 !== 8'hFF) begin mismatched++; $display("FAIL sat_cnt0: got %h want FF", bus.o_cnt0); end
      compared++; if (bus.o_cnt1 !== 8'h00) begin mismatched++; $display("FAIL sat_cnt1: got %h want 00", bus.o_cnt1); end
   endtask

   initial begin
      bus.i_req_valid = 2'b00;
      bus.i_req0_op = 3'b000; bus.i_req0_a = 8'h00; bus.i_req0_b = 8'h00;
      bus.i_req1_op = 3'b000; bus.i_req1_a = 8'h00; bus.i_req1_b = 8'h00;
      bus.i_res_ready = 1'b1;
      test_reset();
      test_req0_add();
      test_req1_sub();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_exec();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
